// File: rtl/toy_pkg.sv
// Shared definitions for the toy CPU bus: responder FSM states, RORW encoding and default widths.
package toy_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 8;

   localparam logic RORW_READ  = 1'b1;
   localparam logic RORW_WRITE = 1'b0;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_ACK  = 2'd2;

endpackage

// File: rtl/toy_mem_array.sv
// Single-port synchronous RAM; read data is registered and only updates on a read strobe.
module toy_mem_array #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rdata;

   // Array contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/toy_mem_resp.sv
// Memory-side responder for the toy CPU bus: request latch, wait-state counter, commit FSM.
// Optional write protection of addresses 0..PROT_TOP is enabled by defining TOY_MEM_WP_EN.
module toy_mem_resp
   import toy_pkg::*;
#(
   parameter int unsigned       DATA_W      = DEF_DATA_W,
   parameter int unsigned       ADDR_W      = DEF_ADDR_W,
   parameter int unsigned       WAIT_CYCLES = 0,
   parameter logic [ADDR_W-1:0] PROT_TOP    = 'h0F
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   input  logic              RORW,
   input  logic              MEM_EN,
   output logic [DATA_W-1:0] RDATA,
   output logic              RDY,
   output logic              ERR
);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rorw;
   logic              r_rdy;
   logic              r_err;

   logic w_commit;
   logic w_prot;
   logic w_we;
   logic w_re;

`ifdef TOY_MEM_WP_EN
   assign w_prot = (r_rorw == RORW_WRITE) && (r_addr <= PROT_TOP);
`else
   assign w_prot = 1'b0;
`endif

   // Reset wins over a pending commit so an abandoned access never touches the array.
   assign w_commit = (r_state == ST_BUSY) && (r_cnt == 4'd0) && !RESET;
   assign w_we     = w_commit && (r_rorw == RORW_WRITE) && !w_prot;
   assign w_re     = w_commit && (r_rorw == RORW_READ);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_rdy   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rdy <= 1'b0;
               r_err <= 1'b0;
               if (MEM_EN) begin
                  r_addr  <= ADDR;
                  r_wdata <= WDATA;
                  r_rorw  <= RORW;
                  r_cnt   <= 4'(WAIT_CYCLES);
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rdy   <= 1'b1;
                  r_err   <= w_prot;
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               r_rdy   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_rdy   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   toy_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (RDATA)
   );

   assign RDY = r_rdy;
   assign ERR = r_err;

endmodule

// File: tb/tb_toy_mem_resp.sv
// Directed bench for toy_mem_resp: three instances with WAIT_CYCLES 0, 3 and 2.
module tb_toy_mem_resp;

`ifdef TOY_MEM_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       rst   [3];
   logic [7:0] addr  [3];
   logic [7:0] wdata [3];
   logic       rorw  [3];
   logic       en    [3];
   logic [7:0] rdata [3];
   logic       rdy   [3];
   logic       err   [3];

   logic [7:0] mdl      [3][256];
   bit         vld      [3][256];
   logic [7:0] exp_last [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      toy_mem_resp #(
         .WAIT_CYCLES ((g == 1) ? 3 : (g == 2) ? 2 : 0)
      ) u_dut (
         .CLK    (CLK),
         .RESET  (rst[g]),
         .ADDR   (addr[g]),
         .WDATA  (wdata[g]),
         .RORW   (rorw[g]),
         .MEM_EN (en[g]),
         .RDATA  (rdata[g]),
         .RDY    (rdy[g]),
         .ERR    (err[g])
      );
   end

   function automatic int wc(input int i);
      return (i == 1) ? 3 : (i == 2) ? 2 : 0;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One isolated access; inputs are scrambled while busy to prove the latched copy is used.
   task automatic acc(input int i, input logic rw, input logic [7:0] a, input logic [7:0] d);
      logic prot;
      prot = WP_ON && (rw == 1'b0) && (a <= 8'h0F);
      en[i] = 1'b1; rorw[i] = rw; addr[i] = a; wdata[i] = d;
      step();
      en[i] = 1'b0; rorw[i] = ~rw; addr[i] = a + 8'd1; wdata[i] = ~d;
      chk("rdy_low_capture", 32'(rdy[i]), 32'd0);
      for (int j = 0; j < wc(i); j++) begin
         step();
         chk("rdy_low_wait", 32'(rdy[i]), 32'd0);
         chk("rdata_hold_wait", 32'(rdata[i]), 32'(exp_last[i]));
      end
      step();
      chk("rdy_pulse", 32'(rdy[i]), 32'd1);
      chk("err_at_rdy", 32'(err[i]), 32'(prot));
      if (rw) begin
         if (vld[i][a]) begin
            chk("read_data", 32'(rdata[i]), 32'(mdl[i][a]));
         end else begin
            // Unwritten location: content unknown, adopt it as the reference.
            mdl[i][a] = rdata[i];
            vld[i][a] = 1'b1;
         end
         exp_last[i] = mdl[i][a];
      end else begin
         chk("rdata_kept_on_write", 32'(rdata[i]), 32'(exp_last[i]));
         if (!prot) begin
            mdl[i][a] = d;
            vld[i][a] = 1'b1;
         end
      end
      step();
      chk("rdy_one_cycle", 32'(rdy[i]), 32'd0);
      chk("err_one_cycle", 32'(err[i]), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; en[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00; rorw[i] = 1'b1;
         exp_last[i] = 8'h00;
      end
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         chk("reset_rdata", 32'(rdata[i]), 32'd0);
         chk("reset_rdy", 32'(rdy[i]), 32'd0);
         chk("reset_err", 32'(err[i]), 32'd0);
         rst[i] = 1'b0;
      end
      step();

      // WAIT_CYCLES=0: write then read back.
      acc(0, 1'b0, 8'h20, 8'hAA);
      acc(0, 1'b1, 8'h20, 8'h00);
      chk("t1_rdata", 32'(rdata[0]), 32'hAA);

      // WAIT_CYCLES=3: RDY at k+4, ADDR moved to 8'h21 while busy.
      acc(1, 1'b0, 8'h21, 8'h3C);
      acc(1, 1'b0, 8'h20, 8'hAA);
      acc(1, 1'b1, 8'h20, 8'h00);
      chk("t2_rdata", 32'(rdata[1]), 32'hAA);

      // Back-to-back with MEM_EN held high: RDY every 3 cycles.
      en[0] = 1'b1;
      for (int r = 0; r < 3; r++) begin
         rorw[0]  = (r == 2);
         addr[0]  = (r == 1) ? 8'h11 : 8'h10;
         wdata[0] = (r == 1) ? 8'h02 : 8'h01;
         step();
         chk("b2b_capture", 32'(rdy[0]), 32'd0);
         step();
         chk("b2b_rdy", 32'(rdy[0]), 32'd1);
         if (r == 2) begin
            chk("b2b_rdata", 32'(rdata[0]), 32'h01);
            en[0] = 1'b0;
         end
         step();
         chk("b2b_ack", 32'(rdy[0]), 32'd0);
      end
      mdl[0][8'h10] = 8'h01; vld[0][8'h10] = 1'b1;
      mdl[0][8'h11] = 8'h02; vld[0][8'h11] = 1'b1;
      exp_last[0] = 8'h01;

      // WAIT_CYCLES=2: reset during BUSY abandons the write.
      acc(2, 1'b0, 8'h30, 8'h77);
      en[2] = 1'b1; rorw[2] = 1'b0; addr[2] = 8'h30; wdata[2] = 8'hFE;
      step();
      en[2] = 1'b0;
      step();
      rst[2] = 1'b1;
      step();
      rst[2] = 1'b0;
      chk("rst_rdata", 32'(rdata[2]), 32'd0);
      chk("rst_rdy", 32'(rdy[2]), 32'd0);
      chk("rst_err", 32'(err[2]), 32'd0);
      exp_last[2] = 8'h00;
      for (int j = 0; j < 4; j++) begin
         step();
         chk("rst_no_rdy", 32'(rdy[2]), 32'd0);
      end
      acc(2, 1'b1, 8'h30, 8'h00);
      chk("rst_old_value", 32'(rdata[2]), 32'h77);

      // RDATA moves only on read commits.
      acc(0, 1'b0, 8'h41, 8'h00);
      acc(0, 1'b1, 8'h20, 8'h00);
      acc(0, 1'b0, 8'h40, 8'h55);
      chk("t5_rdata_after_write", 32'(rdata[0]), 32'hAA);
      acc(0, 1'b1, 8'h41, 8'h00);
      chk("t5_rdata_read", 32'(rdata[0]), 32'h00);

      // Protection boundary (ERR only when TOY_MEM_WP_EN is defined).
      acc(0, 1'b1, 8'h05, 8'h00);
      acc(0, 1'b0, 8'h05, 8'hFF);
      acc(0, 1'b1, 8'h05, 8'h00);
      acc(0, 1'b0, 8'h10, 8'h99);
      acc(0, 1'b1, 8'h10, 8'h00);
      chk("t6_unprot_write", 32'(rdata[0]), 32'h99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
